// File: rtl/writeback_pc_unit_if.sv
// Bus bundle between the upstream pipeline stage and writeback_pc_unit.
// Carries the instruction handshake, decoded control and data fields,
// the UART receive port, the write-back strobe/data and the PC outputs.
// master: upstream/environment side; slave: the write-back/PC unit.
interface writeback_pc_unit_if #(
  parameter int INST_MEM_WIDTH = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int INDEX_WIDTH    = 26
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      RegWrite;
  logic [1:0]                MemtoReg;
  logic [1:0]                Branch;
  logic [DATA_WIDTH-1:0]     read_data;
  logic [DATA_WIDTH-1:0]     alu_result;
  logic [DATA_WIDTH-1:0]     register_data;
  logic [4:0]                rd;
  logic [INDEX_WIDTH-1:0]    inst_index;
  logic [INST_MEM_WIDTH-1:0] pc1;
  logic [INST_MEM_WIDTH-1:0] pc2;
  logic                      input_valid;
  logic [DATA_WIDTH-1:0]     input_data;
  logic                      input_ack;
  logic                      wb_en;
  logic [4:0]                wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      flush;
  logic [INST_MEM_WIDTH-1:0] pc_generated;
  logic [INST_MEM_WIDTH-1:0] pc1_next;

  modport master (
    output in_valid, RegWrite, MemtoReg, Branch, read_data, alu_result,
           register_data, rd, inst_index, pc1, pc2, input_valid, input_data,
    input  in_ready, input_ack, wb_en, wb_rd, wb_data, flush,
           pc_generated, pc1_next
  );

  modport slave (
    input  in_valid, RegWrite, MemtoReg, Branch, read_data, alu_result,
           register_data, rd, inst_index, pc1, pc2, input_valid, input_data,
    output in_ready, input_ack, wb_en, wb_rd, wb_data, flush,
           pc_generated, pc1_next
  );
endinterface

// File: rtl/writeback_pc_unit.sv
// Final pipeline stage: buffers one instruction, selects write-back data
// (ALU / load / link PC / UART input), resolves branches and jumps, owns
// the architectural PC and stalls while a UART-input instruction waits.
//
// Optional build macro PERF_COUNTERS_EN adds saturating stall, taken and
// retired counters as extra output ports.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; accepts a new instruction when not stalling
// WAIT_IN | buffered UART-input instruction waiting for input_valid
module writeback_pc_unit #(
  parameter int INST_MEM_WIDTH = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int INDEX_WIDTH    = 26
) (
  input  logic CLK,
  input  logic reset,
  writeback_pc_unit_if.slave bus
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] taken_count,
  output logic [31:0] retired_count
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_IN = 1'b1
  } state_t;

  state_t state_q, state_d;

  // buffered instruction
  logic                      v_q;
  logic                      rw_q;
  logic [1:0]                mtr_q;
  logic [1:0]                br_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [DATA_WIDTH-1:0]     alu_q;
  logic [INST_MEM_WIDTH-1:0] jr_q;
  logic [4:0]                rd_q;
  logic [INST_MEM_WIDTH-1:0] idx_q;
  logic [INST_MEM_WIDTH-1:0] pc1_q;
  logic [INST_MEM_WIDTH-1:0] pc2_q;

  logic [INST_MEM_WIDTH-1:0] pc_q;
  logic [INST_MEM_WIDTH-1:0] pc_target;
  logic [DATA_WIDTH-1:0]     wb_sel;

  logic uart_sel;
  logic stall_now;
  logic taken;
  logic pc_edge;
  logic accept;
  logic in_ready_c;
  logic ack_c;
  logic flush_c;

  // Only the low address bits of the jump sources ever reach the PC.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{bus.register_data[DATA_WIDTH-1:INST_MEM_WIDTH],
                            bus.inst_index[INDEX_WIDTH-1:INST_MEM_WIDTH]};

  assign uart_sel  = v_q && (mtr_q == 2'b11);
  assign stall_now = uart_sel && !bus.input_valid;
  assign taken     = ((br_q == 2'b00) && alu_q[0]) || (br_q == 2'b01) || (br_q == 2'b10);
  assign pc_edge   = v_q && !stall_now;
  assign accept    = bus.in_valid && in_ready_c;

  // FSM state register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state plus handshake, UART pop and flush outputs
  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    ack_c      = 1'b0;
    flush_c    = 1'b0;
    case (state_q)
      RUN: begin
        in_ready_c = !stall_now;
        ack_c      = uart_sel && bus.input_valid;
        flush_c    = v_q && taken && !stall_now;
        if (stall_now) state_d = WAIT_IN;
      end
      WAIT_IN: begin
        // The releasing cycle retires the waiting instruction but does not
        // accept a new one; the upstream sees in_ready only from RUN.
        if (bus.input_valid) begin
          state_d = RUN;
          ack_c   = uart_sel;
          flush_c = v_q && taken;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Stage buffer: hold while stalled, otherwise capture the accepted
  // instruction; an instruction accepted under flush is squashed via v.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      v_q     <= 1'b0;
      rw_q    <= 1'b0;
      mtr_q   <= 2'b00;
      br_q    <= 2'b11;
      rdata_q <= '0;
      alu_q   <= '0;
      jr_q    <= '0;
      rd_q    <= 5'd0;
      idx_q   <= '0;
      pc1_q   <= '0;
      pc2_q   <= '0;
    end else if (!stall_now) begin
      v_q <= accept && !flush_c;
      if (accept) begin
        rw_q    <= bus.RegWrite;
        mtr_q   <= bus.MemtoReg;
        br_q    <= bus.Branch;
        rdata_q <= bus.read_data;
        alu_q   <= bus.alu_result;
        jr_q    <= bus.register_data[INST_MEM_WIDTH-1:0];
        rd_q    <= bus.rd;
        idx_q   <= bus.inst_index[INST_MEM_WIDTH-1:0];
        pc1_q   <= bus.pc1;
        pc2_q   <= bus.pc2;
      end
    end
  end

  // Next-PC selection for the buffered instruction
  always_comb begin
    pc_target = pc1_q;
    case (br_q)
      2'b00:   if (alu_q[0]) pc_target = pc2_q;
      2'b01:   pc_target = idx_q;
      2'b10:   pc_target = jr_q;
      default: pc_target = pc1_q;
    endcase
  end

  // Architectural PC: advances once per retired instruction
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)        pc_q <= '0;
    else if (pc_edge) pc_q <= pc_target;
  end

  // Write-back source selection
  always_comb begin
    wb_sel = alu_q;
    case (mtr_q)
      2'b00:   wb_sel = alu_q;
      2'b01:   wb_sel = rdata_q;
      2'b10:   wb_sel = {{(DATA_WIDTH-INST_MEM_WIDTH){1'b0}}, pc1_q};
      default: wb_sel = bus.input_data;
    endcase
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.input_ack    = ack_c;
  assign bus.flush        = flush_c;
  assign bus.wb_en        = v_q && rw_q && (rd_q != 5'd0) &&
                            ((mtr_q != 2'b11) || bus.input_valid);
  assign bus.wb_rd        = v_q ? rd_q : 5'd0;
  assign bus.wb_data      = v_q ? wb_sel : '0;
  assign bus.pc_generated = pc_q;
  assign bus.pc1_next     = pc_q + INST_MEM_WIDTH'(1);

`ifdef PERF_COUNTERS_EN
  logic [31:0] stall_cnt;
  logic [31:0] taken_cnt;
  logic [31:0] retired_cnt;

  // Saturating event counters
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      stall_cnt   <= 32'd0;
      taken_cnt   <= 32'd0;
      retired_cnt <= 32'd0;
    end else begin
      if ((state_q == WAIT_IN) && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush_c && (taken_cnt != 32'hFFFF_FFFF))
        taken_cnt <= taken_cnt + 32'd1;
      if (pc_edge && (retired_cnt != 32'hFFFF_FFFF))
        retired_cnt <= retired_cnt + 32'd1;
    end
  end

  assign stall_cycles  = stall_cnt;
  assign taken_count   = taken_cnt;
  assign retired_count = retired_cnt;
`endif

endmodule
